keymem_rd_arbiter: RTL and testbench
====================================

// Module: keymem_rd_arbiter
// PURPOSE
// - Shares the two key-memory read ports (A/B) between two requesters: req0 = skdecode, req1 = pk/sig side reader.
// - Grants whole operations. Once granted, a requester owns both ports until it drops its request.
// - Returns read data only to the owner; the non-owner sees zeros, so key material never crosses requesters.
// - Sits between the requesters' kmem_*_rd_req outputs and the key memory, in the top-level decode datapath.
// PARAMETERS
// - KMEM_RD_LAT     1   key-memory read latency in cycles (1..3)
// - AHB_DATA_WIDTH  32  key-memory data width
// - ABR_MEM_ADDR_WIDTH comes from abr_params_pkg; mem_if_t and RW_* encodings come from the same package.
// PORTS
// - clk                 in   1     clock
// - reset_n             in   1     async active-low reset
// - zeroize             in   1     sync clear of all state
// - req_i[1:0]          in   2     operation request per requester; held high for the whole operation
// - gnt_o[1:0]          out  2     registered one-hot ownership grant
// - rq_a_rd_req_i[1:0]  in   2x mem_if_t  per-requester port-A read request
// - rq_b_rd_req_i[1:0]  in   2x mem_if_t  per-requester port-B read request
// - kmem_a_rd_req_o     out  mem_if_t     to key memory port A
// - kmem_b_rd_req_o     out  mem_if_t     to key memory port B
// - kmem_a_rd_data_i    in   AHB_DATA_WIDTH  key memory port-A read data
// - kmem_b_rd_data_i    in   AHB_DATA_WIDTH  key memory port-B read data
// - rq_a_rd_data_o[1:0] out  2xAHB_DATA_WIDTH  per-requester port-A data; zero unless valid
// - rq_b_rd_data_o[1:0] out  2xAHB_DATA_WIDTH  per-requester port-B data; zero unless valid
// - rq_a_rd_vld_o[1:0]  out  2     port-A data valid, aligned to the data
// - rq_b_rd_vld_o[1:0]  out  2     port-B data valid, aligned to the data
// - busy_o              out  1     state != IDLE
// - proto_err_o         out  1     sticky protocol error
// BEHAVIOUR
// - Reset/zeroize values
//   - gnt_o=0; kmem_*_rd_req_o = {RW_IDLE, addr 0}; all rd_vld=0; all rd_data=0.
//   - busy_o=0; proto_err_o=0; last_gnt=1, so requester 0 wins the first tie.
//   - Zeroize also clears the latency pipeline and forces the FSM to IDLE, including mid-operation.
// - FSM states: IDLE, OWN0, OWN1, DRAIN.
//   - IDLE: if exactly one req_i is high, go to OWN of that requester. If both are high, go to OWN of ~last_gnt (round-robin).
//   - gnt_o is asserted in the first cycle of OWNx, i.e. one cycle after req is sampled.
//   - OWNx: the owner's rq_*_rd_req_i pass combinationally to kmem_*_rd_req_o. When req_i[x] falls, go to DRAIN and set last_gnt=x.
//   - DRAIN: hold for exactly KMEM_RD_LAT cycles (down-counter); kmem requests forced RW_IDLE; gnt_o=0. Then go to IDLE.
//   - From DRAIN there is no direct re-grant; the earliest new gnt_o comes 1 cycle after IDLE is entered.
// - Request forwarding
//   - Only rd_wr_en==RW_READ is forwarded.
//   - An owner issuing RW_WRITE is forwarded as RW_IDLE and sets proto_err_o.
//   - A non-owner issuing any non-IDLE request is ignored and sets proto_err_o.
//   - Requests issued by the owner in the same cycle it drops req_i are still forwarded.
// - Read return
//   - A per-port shift register of depth KMEM_RD_LAT carries {valid, owner id} for each forwarded read.
//   - rq_p_rd_vld_o[id] and rq_p_rd_data_o[id] = kmem_p_rd_data_i are driven only when the pipe tail is valid. Otherwise data is 0.
//   - Reads in flight complete during DRAIN to the previous owner. Nothing is dropped or reordered.
// - Boundary cases
//   - A request that rises while the other requester owns the ports waits; there is no preemption.
//   - Back-to-back operations by the same requester with the other idle are allowed (full IDLE/DRAIN overhead).
//   - proto_err_o clears only on reset or zeroize.
// STRUCTURE
// - Shared package (abr_params_pkg): mem_if_t, RW_* encodings, ABR_MEM_ADDR_WIDTH.
// - Local enum kmarb_state_e is defined in skdecode_defines_pkg.
// - One sub-module, kmarb_rd_pipe (valid+id delay line, depth KMEM_RD_LAT), instantiated once per port.
// TESTING
// - Tie: req_i=2'b11 after reset -> gnt_o=01 next cycle; req0 drops -> DRAIN 1 cycle -> IDLE -> gnt_o=10.
// - Owner 0 reads A@0x10, B@0x11 with kmem data 0xA5A5_0001/0xA5A5_0002.
//   - 1 cycle later: rq_a_rd_vld_o=01 with data 0xA5A5_0001, port B likewise.
//   - rq_*_rd_data_o[1] = 0 throughout.
// - KMEM_RD_LAT=3: owner issues a read in its final req cycle -> data is delivered to it during DRAIN, 3 cycles later; no grant is issued during DRAIN.
// - Non-owner 1 issues RW_READ while owner 0 is active -> kmem sees only owner-0 traffic; proto_err_o=1 and stays high until zeroize.
// - zeroize asserted mid-OWN1 with reads in flight -> next cycle FSM=IDLE, gnt_o=0, all vld=0, kmem req RW_IDLE.
// - Owner issues RW_WRITE -> kmem port stays RW_IDLE and proto_err_o=1.

Source files
------------

// File: rtl/abr_params_pkg.sv
// Shared memory-interface types: request struct, read/write encodings, address width.
package abr_params_pkg;

    localparam int ABR_MEM_ADDR_WIDTH = 15;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'b00,
        RW_READ  = 2'b01,
        RW_WRITE = 2'b10
    } rw_e;

    typedef struct packed {
        rw_e                           rd_wr_en;
        logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
    } mem_if_t;

endpackage

// File: rtl/skdecode_defines_pkg.sv
// Local definitions for the skdecode datapath; holds the key-memory arbiter state encoding.
package skdecode_defines_pkg;

    typedef enum logic [1:0] {
        KMARB_IDLE  = 2'b00,
        KMARB_OWN0  = 2'b01,
        KMARB_OWN1  = 2'b10,
        KMARB_DRAIN = 2'b11
    } kmarb_state_e;

endpackage

// File: rtl/kmarb_rd_pipe.sv
// Delay line of depth DEPTH carrying {valid, owner id} for each forwarded key-memory read.
module kmarb_rd_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic zeroize,
    input  logic in_vld,
    input  logic in_id,
    output logic out_vld,
    output logic out_id
);

    logic [DEPTH-1:0] vld_reg;
    logic [DEPTH-1:0] id_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_reg <= '0;
            id_reg  <= '0;
        end else if (zeroize) begin
            vld_reg <= '0;
            id_reg  <= '0;
        end else begin
            vld_reg[0] <= in_vld;
            id_reg[0]  <= in_id;
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_reg[i] <= vld_reg[i-1];
                id_reg[i]  <= id_reg[i-1];
            end
        end
    end

    assign out_vld = vld_reg[DEPTH-1];
    assign out_id  = id_reg[DEPTH-1];

endmodule

// File: rtl/keymem_rd_arbiter.sv
// Grants both key-memory read ports to one requester per operation and returns
// read data only to the requester that issued the read.
module keymem_rd_arbiter
    import abr_params_pkg::*;
    import skdecode_defines_pkg::*;
#(
    parameter int KMEM_RD_LAT    = 1,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      zeroize,
    input  logic [1:0]                req_i,
    output logic [1:0]                gnt_o,
    input  mem_if_t                   rq_a_rd_req_i [1:0],
    input  mem_if_t                   rq_b_rd_req_i [1:0],
    output mem_if_t                   kmem_a_rd_req_o,
    output mem_if_t                   kmem_b_rd_req_o,
    input  logic [AHB_DATA_WIDTH-1:0] kmem_a_rd_data_i,
    input  logic [AHB_DATA_WIDTH-1:0] kmem_b_rd_data_i,
    output logic [AHB_DATA_WIDTH-1:0] rq_a_rd_data_o [1:0],
    output logic [AHB_DATA_WIDTH-1:0] rq_b_rd_data_o [1:0],
    output logic [1:0]                rq_a_rd_vld_o,
    output logic [1:0]                rq_b_rd_vld_o,
    output logic                      busy_o,
    output logic                      proto_err_o
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(KMEM_RD_LAT - 1);

    kmarb_state_e     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_gnt_reg, last_gnt_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic             proto_err_reg, proto_err_next;

    logic    own_vld;
    logic    own_id;
    mem_if_t own_a_req;
    mem_if_t own_b_req;
    logic    fwd_a;
    logic    fwd_b;
    logic    own_write;
    logic [1:0] nonown_err;

    logic pa_vld, pa_id, pb_vld, pb_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= KMARB_IDLE;
            cnt_reg       <= '0;
            last_gnt_reg  <= 1'b1;
            gnt_reg       <= '0;
            proto_err_reg <= 1'b0;
        end else if (zeroize) begin
            state_reg     <= KMARB_IDLE;
            cnt_reg       <= '0;
            last_gnt_reg  <= 1'b1;
            gnt_reg       <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_gnt_reg  <= last_gnt_next;
            gnt_reg       <= gnt_next;
            proto_err_reg <= proto_err_next;
        end
    end

    // Ownership is only released by the owner dropping its request; no preemption.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        last_gnt_next = last_gnt_reg;
        unique case (state_reg)
            KMARB_IDLE: begin
                if (req_i == 2'b11) begin
                    state_next = last_gnt_reg ? KMARB_OWN0 : KMARB_OWN1;
                end else if (req_i[0]) begin
                    state_next = KMARB_OWN0;
                end else if (req_i[1]) begin
                    state_next = KMARB_OWN1;
                end
            end
            KMARB_OWN0: begin
                if (!req_i[0]) begin
                    state_next    = KMARB_DRAIN;
                    cnt_next      = DRAIN_LOAD;
                    last_gnt_next = 1'b0;
                end
            end
            KMARB_OWN1: begin
                if (!req_i[1]) begin
                    state_next    = KMARB_DRAIN;
                    cnt_next      = DRAIN_LOAD;
                    last_gnt_next = 1'b1;
                end
            end
            KMARB_DRAIN: begin
                if (cnt_reg == '0) begin
                    state_next = KMARB_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = KMARB_IDLE;
        endcase
    end

    always_comb begin
        gnt_next = 2'b00;
        if (state_next == KMARB_OWN0) gnt_next = 2'b01;
        if (state_next == KMARB_OWN1) gnt_next = 2'b10;
    end

    assign own_vld   = (state_reg == KMARB_OWN0) || (state_reg == KMARB_OWN1);
    assign own_id    = (state_reg == KMARB_OWN1);
    assign own_a_req = rq_a_rd_req_i[own_id];
    assign own_b_req = rq_b_rd_req_i[own_id];
    assign fwd_a     = own_vld && (own_a_req.rd_wr_en == RW_READ);
    assign fwd_b     = own_vld && (own_b_req.rd_wr_en == RW_READ);

    always_comb begin
        kmem_a_rd_req_o = '0;
        kmem_b_rd_req_o = '0;
        if (fwd_a) kmem_a_rd_req_o = own_a_req;
        if (fwd_b) kmem_b_rd_req_o = own_b_req;
    end

    assign own_write = own_vld && ((own_a_req.rd_wr_en == RW_WRITE) ||
                                   (own_b_req.rd_wr_en == RW_WRITE));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            // Outside OWN states nobody owns the ports, so any traffic is a violation.
            assign nonown_err[gi] = !(own_vld && (own_id == 1'(gi))) &&
                                    ((rq_a_rd_req_i[gi].rd_wr_en != RW_IDLE) ||
                                     (rq_b_rd_req_i[gi].rd_wr_en != RW_IDLE));

            assign rq_a_rd_vld_o[gi]  = pa_vld && (pa_id == 1'(gi));
            assign rq_b_rd_vld_o[gi]  = pb_vld && (pb_id == 1'(gi));
            assign rq_a_rd_data_o[gi] = rq_a_rd_vld_o[gi] ? kmem_a_rd_data_i : '0;
            assign rq_b_rd_data_o[gi] = rq_b_rd_vld_o[gi] ? kmem_b_rd_data_i : '0;
        end
    endgenerate

    assign proto_err_next = proto_err_reg || own_write || (|nonown_err);

    kmarb_rd_pipe #(.DEPTH(KMEM_RD_LAT)) u_pipe_a (
        .clk     (clk),
        .reset_n (reset_n),
        .zeroize (zeroize),
        .in_vld  (fwd_a),
        .in_id   (own_id),
        .out_vld (pa_vld),
        .out_id  (pa_id)
    );

    kmarb_rd_pipe #(.DEPTH(KMEM_RD_LAT)) u_pipe_b (
        .clk     (clk),
        .reset_n (reset_n),
        .zeroize (zeroize),
        .in_vld  (fwd_b),
        .in_id   (own_id),
        .out_vld (pb_vld),
        .out_id  (pb_id)
    );

    assign gnt_o       = gnt_reg;
    assign busy_o      = (state_reg != KMARB_IDLE);
    assign proto_err_o = proto_err_reg;

endmodule

// File: tb/tb_keymem_rd_arbiter.sv
// Directed bench for keymem_rd_arbiter: one instance at read latency 1, one at latency 3.
module tb_keymem_rd_arbiter;
    import abr_params_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic zeroize;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    // Latency-1 instance
    logic [1:0]  req, gnt, va, vb;
    mem_if_t     rq_a [1:0];
    mem_if_t     rq_b [1:0];
    mem_if_t     ka, kb;
    logic [31:0] kda, kdb;
    logic [31:0] rda [1:0];
    logic [31:0] rdb [1:0];
    logic        busy, perr;

    // Latency-3 instance
    logic [1:0]  req3, gnt3, va3, vb3;
    mem_if_t     rq_a3 [1:0];
    mem_if_t     rq_b3 [1:0];
    mem_if_t     ka3, kb3;
    logic [31:0] kda3, kdb3;
    logic [31:0] rda3 [1:0];
    logic [31:0] rdb3 [1:0];
    logic        busy3, perr3;

    keymem_rd_arbiter #(.KMEM_RD_LAT(1), .AHB_DATA_WIDTH(32)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .req_i(req), .gnt_o(gnt),
        .rq_a_rd_req_i(rq_a), .rq_b_rd_req_i(rq_b),
        .kmem_a_rd_req_o(ka), .kmem_b_rd_req_o(kb),
        .kmem_a_rd_data_i(kda), .kmem_b_rd_data_i(kdb),
        .rq_a_rd_data_o(rda), .rq_b_rd_data_o(rdb),
        .rq_a_rd_vld_o(va), .rq_b_rd_vld_o(vb),
        .busy_o(busy), .proto_err_o(perr)
    );

    keymem_rd_arbiter #(.KMEM_RD_LAT(3), .AHB_DATA_WIDTH(32)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .req_i(req3), .gnt_o(gnt3),
        .rq_a_rd_req_i(rq_a3), .rq_b_rd_req_i(rq_b3),
        .kmem_a_rd_req_o(ka3), .kmem_b_rd_req_o(kb3),
        .kmem_a_rd_data_i(kda3), .kmem_b_rd_data_i(kdb3),
        .rq_a_rd_data_o(rda3), .rq_b_rd_data_o(rdb3),
        .rq_a_rd_vld_o(va3), .rq_b_rd_vld_o(vb3),
        .busy_o(busy3), .proto_err_o(perr3)
    );

    function automatic mem_if_t mk(input rw_e op, input int addr);
        mem_if_t m;
        m.rd_wr_en = op;
        m.addr     = ABR_MEM_ADDR_WIDTH'(addr);
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 2; i++) begin
            rq_a[i] = mk(RW_IDLE, 0); rq_b[i] = mk(RW_IDLE, 0);
            rq_a3[i] = mk(RW_IDLE, 0); rq_b3[i] = mk(RW_IDLE, 0);
        end
    endtask

    task automatic do_zeroize();
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; zeroize = 1'b0; req = 2'b00; req3 = 2'b00;
        clear_reqs();
        repeat (2) step();
        vectors++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        vectors++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b exp 0", perr); end
        vectors++; if (ka !== mk(RW_IDLE, 0)) begin errors++; $display("FAIL reset_kmem_a: got %h exp %h", ka, mk(RW_IDLE, 0)); end
        vectors++; if ({va, vb} !== 4'b0000) begin errors++; $display("FAIL reset_vld: got %b exp 0000", {va, vb}); end
        vectors++; if (rda[0] !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", rda[0]); end
        reset_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_tie();
        req = 2'b11;
        step();
        vectors++; if (gnt !== 2'b01) begin errors++; $display("FAIL tie_gnt: got %b exp 01", gnt); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL tie_busy: got %b exp 1", busy); end
        step();
        vectors++; if (gnt !== 2'b01) begin errors++; $display("FAIL tie_nopreempt: got %b exp 01", gnt); end
        req = 2'b10;
        step();
        vectors++; if ({gnt, busy} !== 3'b001) begin errors++; $display("FAIL tie_drain: got gnt/busy %b exp 001", {gnt, busy}); end
        step();
        vectors++; if ({gnt, busy} !== 3'b000) begin errors++; $display("FAIL tie_idle: got gnt/busy %b exp 000", {gnt, busy}); end
        step();
        vectors++; if (gnt !== 2'b10) begin errors++; $display("FAIL tie_gnt1: got %b exp 10", gnt); end
        req = 2'b00;
        repeat (2) step();
        $display("test_tie done");
    endtask

    task automatic test_read();
        kda = 32'hA5A5_0001; kdb = 32'hA5A5_0002;
        req = 2'b01;
        step();
        rq_a[0] = mk(RW_READ, 'h10); rq_b[0] = mk(RW_READ, 'h11);
        #1;
        vectors++; if (ka !== mk(RW_READ, 'h10)) begin errors++; $display("FAIL read_kmem_a: got %h exp %h", ka, mk(RW_READ, 'h10)); end
        vectors++; if (kb !== mk(RW_READ, 'h11)) begin errors++; $display("FAIL read_kmem_b: got %h exp %h", kb, mk(RW_READ, 'h11)); end
        step();
        clear_reqs();
        #1;
        vectors++; if (va !== 2'b01) begin errors++; $display("FAIL read_vld_a: got %b exp 01", va); end
        vectors++; if (rda[0] !== 32'hA5A5_0001) begin errors++; $display("FAIL read_data_a0: got %h exp a5a50001", rda[0]); end
        vectors++; if (rda[1] !== 32'h0) begin errors++; $display("FAIL read_data_a1: got %h exp 0", rda[1]); end
        vectors++; if (vb !== 2'b01) begin errors++; $display("FAIL read_vld_b: got %b exp 01", vb); end
        vectors++; if (rdb[0] !== 32'hA5A5_0002) begin errors++; $display("FAIL read_data_b0: got %h exp a5a50002", rdb[0]); end
        vectors++; if (rdb[1] !== 32'h0) begin errors++; $display("FAIL read_data_b1: got %h exp 0", rdb[1]); end
        step();
        vectors++; if ({va, vb} !== 4'b0000 || rda[0] !== 32'h0) begin errors++; $display("FAIL read_after: got vld %b data %h exp 0", {va, vb}, rda[0]); end
        req = 2'b00;
        repeat (2) step();
        vectors++; if (perr !== 1'b0) begin errors++; $display("FAIL read_perr: got %b exp 0", perr); end
        $display("test_read done");
    endtask

    task automatic test_back_to_back();
        req = 2'b01;
        step();
        vectors++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_gnt_first: got %b exp 01", gnt); end
        req = 2'b00;
        step();
        req = 2'b01;
        vectors++; if (gnt !== 2'b00) begin errors++; $display("FAIL b2b_drain: got %b exp 00", gnt); end
        step();
        vectors++; if (gnt !== 2'b00) begin errors++; $display("FAIL b2b_no_regrant: got %b exp 00", gnt); end
        step();
        vectors++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_gnt_second: got %b exp 01", gnt); end
        req = 2'b00;
        repeat (2) step();
        $display("test_back_to_back done");
    endtask

    task automatic test_nonowner();
        req = 2'b01;
        step();
        rq_a[0] = mk(RW_READ, 'h20); rq_a[1] = mk(RW_READ, 'h30);
        #1;
        vectors++; if (ka !== mk(RW_READ, 'h20)) begin errors++; $display("FAIL nonown_kmem: got %h exp %h", ka, mk(RW_READ, 'h20)); end
        step();
        clear_reqs();
        #1;
        vectors++; if (perr !== 1'b1) begin errors++; $display("FAIL nonown_perr: got %b exp 1", perr); end
        vectors++; if (va !== 2'b01 || rda[1] !== 32'h0) begin errors++; $display("FAIL nonown_vld: got %b/%h exp 01/0", va, rda[1]); end
        req = 2'b00;
        repeat (3) step();
        vectors++; if (perr !== 1'b1) begin errors++; $display("FAIL nonown_sticky: got %b exp 1", perr); end
        do_zeroize();
        vectors++; if (perr !== 1'b0) begin errors++; $display("FAIL nonown_zclear: got %b exp 0", perr); end
        $display("test_nonowner done");
    endtask

    task automatic test_write();
        req = 2'b01;
        step();
        rq_b[0] = mk(RW_WRITE, 'h5);
        #1;
        vectors++; if (kb !== mk(RW_IDLE, 0)) begin errors++; $display("FAIL write_kmem_b: got %h exp %h", kb, mk(RW_IDLE, 0)); end
        step();
        clear_reqs();
        #1;
        vectors++; if (perr !== 1'b1) begin errors++; $display("FAIL write_perr: got %b exp 1", perr); end
        vectors++; if (vb !== 2'b00) begin errors++; $display("FAIL write_vld: got %b exp 00", vb); end
        req = 2'b00;
        repeat (2) step();
        do_zeroize();
        $display("test_write done");
    endtask

    task automatic test_zeroize();
        req = 2'b10;
        step();
        rq_a[1] = mk(RW_READ, 'h40);
        step();
        vectors++; if (va !== 2'b10) begin errors++; $display("FAIL zero_pre_vld: got %b exp 10", va); end
        zeroize = 1'b1; req = 2'b00;
        step();
        zeroize = 1'b0;
        vectors++; if ({gnt, busy} !== 3'b000) begin errors++; $display("FAIL zero_fsm: got gnt/busy %b exp 000", {gnt, busy}); end
        vectors++; if ({va, vb} !== 4'b0000 || rda[1] !== 32'h0) begin errors++; $display("FAIL zero_vld: got %b/%h exp 0", {va, vb}, rda[1]); end
        vectors++; if (ka !== mk(RW_IDLE, 0)) begin errors++; $display("FAIL zero_kmem: got %h exp %h", ka, mk(RW_IDLE, 0)); end
        clear_reqs();
        do_zeroize();
        $display("test_zeroize done");
    endtask

    task automatic test_lat3();
        kda3 = 32'hC3C3_0003; kdb3 = 32'hC3C3_0004;
        req3 = 2'b01;
        step();
        vectors++; if (gnt3 !== 2'b01) begin errors++; $display("FAIL lat3_gnt: got %b exp 01", gnt3); end
        req3 = 2'b00; rq_a3[0] = mk(RW_READ, 'h40);
        #1;
        vectors++; if (ka3 !== mk(RW_READ, 'h40)) begin errors++; $display("FAIL lat3_kmem: got %h exp %h", ka3, mk(RW_READ, 'h40)); end
        step();
        clear_reqs();
        req3 = 2'b10;
        for (int c = 1; c <= 2; c++) begin
            vectors++; if ({gnt3, va3} !== 4'b0000) begin errors++; $display("FAIL lat3_drain%0d: got gnt/vld %b exp 0000", c, {gnt3, va3}); end
            step();
        end
        vectors++; if (va3 !== 2'b01 || rda3[0] !== 32'hC3C3_0003) begin errors++; $display("FAIL lat3_data: got %b/%h exp 01/c3c30003", va3, rda3[0]); end
        vectors++; if (rda3[1] !== 32'h0) begin errors++; $display("FAIL lat3_data1: got %h exp 0", rda3[1]); end
        vectors++; if ({gnt3, busy3} !== 3'b001) begin errors++; $display("FAIL lat3_drain3: got gnt/busy %b exp 001", {gnt3, busy3}); end
        step();
        vectors++; if ({gnt3, busy3, va3} !== 5'b00000) begin errors++; $display("FAIL lat3_idle: got %b exp 00000", {gnt3, busy3, va3}); end
        step();
        vectors++; if (gnt3 !== 2'b10) begin errors++; $display("FAIL lat3_gnt1: got %b exp 10", gnt3); end
        vectors++; if (perr3 !== 1'b0) begin errors++; $display("FAIL lat3_perr: got %b exp 0", perr3); end
        req3 = 2'b00;
        repeat (4) step();
        $display("test_lat3 done");
    endtask

    initial begin
        kda = '0; kdb = '0; kda3 = '0; kdb3 = '0;
        test_reset();
        test_tie();
        test_read();
        test_back_to_back();
        test_nonowner();
        test_write();
        test_zeroize();
        test_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
